// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-port bundle between the requesters, the data-memory
// arbiter and the data memory. Requester i occupies bit/lane i of the packed fields.
interface dmem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [5:0]  req_funct3;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_funct3;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_address, mem_write_data, mem_funct3, mem_read_enable, mem_write_enable
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_address, mem_write_data, mem_funct3, mem_read_enable, mem_write_enable
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the load/store unit and the
// DMA/debug loader: accept, one ACCESS cycle on the memory port, one RESP pulse.
module dmem_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int NREQ      = 2
) (
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              cmd_we;
    logic              cmd_id;
    logic              cmd_err;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [31:0]       mem_address_q;
    logic [31:0]       mem_write_data_q;
    logic [2:0]        mem_funct3_q;
    logic              mem_re_q;
    logic              mem_we_q;

    logic [NREQ-1:0]   ready_c;
    logic              gnt_id;
    logic              accept;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_f3;
    logic              sel_we;
    logic              sel_err;

    function automatic logic access_err(input logic [31:0] addr, input logic [2:0] f3,
                                        input logic we);
        logic e;
        e = (addr >> ADDR_BITS) != 32'd0;
        if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) e = 1'b1;
        if (f3 == 3'b010 && addr[1:0] != 2'b00) e = 1'b1;
        if (we && !(f3 inside {3'b000, 3'b001, 3'b010})) e = 1'b1;
        if (!we && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) e = 1'b1;
        return e;
    endfunction

    // Grant the lone requester, or on contention the one that did not win last time.
    always_comb begin
        gnt_id = bus.req_valid[1];
        if (&bus.req_valid) gnt_id = ~last_grant;
        ready_c = '0;
        if (state != ACCESS && |bus.req_valid) ready_c[gnt_id] = 1'b1;
        accept    = |ready_c;
        sel_addr  = gnt_id ? bus.req_addr[63:32]  : bus.req_addr[31:0];
        sel_wdata = gnt_id ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        sel_f3    = gnt_id ? bus.req_funct3[5:3]  : bus.req_funct3[2:0];
        sel_we    = bus.req_we[gnt_id];
        sel_err   = access_err(sel_addr, sel_f3, sel_we);
    end

    // The memory address/data/funct3 registers double as the command register, so they
    // naturally hold their last value outside ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            cmd_we           <= 1'b0;
            cmd_id           <= 1'b0;
            cmd_err          <= 1'b0;
            rsp_valid_q      <= '0;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_funct3_q     <= '0;
            mem_re_q         <= 1'b0;
            mem_we_q         <= 1'b0;
        end else begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= '0;
            if (state == ACCESS) begin
                rsp_rdata_q <= (cmd_we || cmd_err) ? 32'd0 : bus.mem_read_data;
                rsp_err_q   <= cmd_err;
                rsp_valid_q <= NREQ'(1) << cmd_id;
                state       <= RESP;
            end else if (accept) begin
                mem_address_q    <= sel_addr;
                mem_write_data_q <= sel_wdata;
                mem_funct3_q     <= sel_f3;
                cmd_we           <= sel_we;
                cmd_id           <= gnt_id;
                cmd_err          <= sel_err;
                last_grant       <= gnt_id;
                mem_we_q         <= sel_we & ~sel_err;
                mem_re_q         <= ~sel_we & ~sel_err;
                state            <= ACCESS;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.req_ready        = ready_c;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_funct3       = mem_funct3_q;
    assign bus.mem_read_enable  = mem_re_q;
    assign bus.mem_write_enable = mem_we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 4 KB byte-addressed data memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   wr_base;

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [7:0]  mem [0:4095];
    logic [11:0] ra;
    logic [7:0]  b0, b1, b2, b3;

    dmem_arbiter_if bus();

    dmem_arbiter #(.ADDR_BITS(12), .NREQ(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory: combinational read by funct3, posedge write; pre_* preloads a word.
    always_comb begin
        ra = bus.mem_address[11:0];
        b0 = mem[ra];
        b1 = mem[ra + 12'd1];
        b2 = mem[ra + 12'd2];
        b3 = mem[ra + 12'd3];
        case (bus.mem_funct3)
            3'b000:  bus.mem_read_data = {{24{b0[7]}}, b0};
            3'b001:  bus.mem_read_data = {{16{b1[7]}}, b1, b0};
            3'b010:  bus.mem_read_data = {b3, b2, b1, b0};
            3'b100:  bus.mem_read_data = {24'd0, b0};
            3'b101:  bus.mem_read_data = {16'd0, b1, b0};
            default: bus.mem_read_data = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            wr_count <= wr_count + 1;
            case (bus.mem_funct3)
                3'b000: mem[ra] <= bus.mem_write_data[7:0];
                3'b001: begin
                    mem[ra]         <= bus.mem_write_data[7:0];
                    mem[ra + 12'd1] <= bus.mem_write_data[15:8];
                end
                3'b010: begin
                    mem[ra]         <= bus.mem_write_data[7:0];
                    mem[ra + 12'd1] <= bus.mem_write_data[15:8];
                    mem[ra + 12'd2] <= bus.mem_write_data[23:16];
                    mem[ra + 12'd3] <= bus.mem_write_data[31:24];
                end
                default: ;
            endcase
        end else if (pre_we) begin
            mem[pre_addr]         <= pre_data[7:0];
            mem[pre_addr + 12'd1] <= pre_data[15:8];
            mem[pre_addr + 12'd2] <= pre_data[23:16];
            mem[pre_addr + 12'd3] <= pre_data[31:24];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic drive(input int id, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
        bus.req_valid[id]          = v;
        bus.req_we[id]             = we;
        bus.req_addr[id*32 +: 32]  = a;
        bus.req_wdata[id*32 +: 32] = d;
        bus.req_funct3[id*3 +: 3]  = f3;
    endtask

    // Single uncontended transaction starting from IDLE.
    task automatic txn(input string tag, input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [1:0] oh;
        int n;
        oh = (id == 1) ? 2'b10 : 2'b01;
        drive(id, 1'b1, we, a, d, f3);
        #1;
        n = 0;
        while (bus.req_ready !== oh && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ".ready"}, {30'd0, bus.req_ready}, {30'd0, oh});
        tick();
        drive(id, 1'b0, we, a, d, f3);
        chk({tag, ".re"}, {31'd0, bus.mem_read_enable}, {31'd0, ~we & ~exp_err});
        chk({tag, ".we"}, {31'd0, bus.mem_write_enable}, {31'd0, we & ~exp_err});
        tick();
        chk({tag, ".rsp_valid"}, {30'd0, bus.rsp_valid}, {30'd0, oh});
        chk({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, ".err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        tick();
        chk({tag, ".idle"}, {30'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus.req_valid = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_funct3 = '0;
        tick();
        tick();
        chk("rst.rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'd0);
        chk("rst.err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst.addr", bus.mem_address, 32'd0);
        chk("rst.wdata", bus.mem_write_data, 32'd0);
        chk("rst.f3", {29'd0, bus.mem_funct3}, 32'd0);
        chk("rst.en", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        chk("rst.ready", {30'd0, bus.req_ready}, 32'd0);
        poke(12'h020, 32'h55667788);
        poke(12'h010, 32'hDEADBEEF);
        poke(12'h000, 32'h01020304);
        poke(12'h030, 32'hA5A5A5A5);
        reset = 1'b0;
        tick();

        // Contention from reset: requester 0 first, then 1, then 0 again.
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
        drive(1, 1'b1, 1'b1, 32'h20, 32'h11223344, 3'b010);
        #1;
        chk("rr.grant0", {30'd0, bus.req_ready}, 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'h20, 32'd0, 3'b010);
        chk("rr.acc0.ready", {30'd0, bus.req_ready}, 32'd0);
        chk("rr.acc0.re", {31'd0, bus.mem_read_enable}, 32'd1);
        chk("rr.acc0.addr", bus.mem_address, 32'h20);
        tick();
        chk("rr.rsp0.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("rr.rsp0.rdata", bus.rsp_rdata, 32'h55667788);
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
        #1;
        chk("rr.grant1", {30'd0, bus.req_ready}, 32'd2);
        tick();
        drive(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010);
        chk("rr.acc1.we", {31'd0, bus.mem_write_enable}, 32'd1);
        chk("rr.acc1.re", {31'd0, bus.mem_read_enable}, 32'd0);
        chk("rr.acc1.wdata", bus.mem_write_data, 32'h11223344);
        tick();
        chk("rr.rsp1.valid", {30'd0, bus.rsp_valid}, 32'd2);
        chk("rr.rsp1.rdata", bus.rsp_rdata, 32'd0);
        chk("rr.grant0b", {30'd0, bus.req_ready}, 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'h20, 32'd0, 3'b010);
        tick();
        chk("rr.rsp0b.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("rr.rsp0b.rdata", bus.rsp_rdata, 32'h11223344);
        tick();

        txn("lw10", 0, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);

        // Byte store then sign/zero-extended reads.
        txn("sb23", 1, 1'b1, 32'h23, 32'h000000AB, 3'b000, 32'd0, 1'b0);
        txn("lbu23", 0, 1'b0, 32'h23, 32'd0, 3'b100, 32'h000000AB, 1'b0);
        txn("lb23", 0, 1'b0, 32'h23, 32'd0, 3'b000, 32'hFFFFFFAB, 1'b0);
        txn("lh22", 1, 1'b0, 32'h22, 32'd0, 3'b001, 32'hFFFFAB22, 1'b0);
        txn("lw20", 0, 1'b0, 32'h20, 32'd0, 3'b010, 32'hAB223344, 1'b0);

        // Error responses never touch memory.
        wr_base = wr_count;
        txn("lh5", 0, 1'b0, 32'h5, 32'd0, 3'b001, 32'd0, 1'b1);
        txn("lw6", 0, 1'b0, 32'h6, 32'd0, 3'b010, 32'd0, 1'b1);
        txn("sw1000", 1, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b010, 32'd0, 1'b1);
        txn("ldf3", 0, 1'b0, 32'h8, 32'd0, 3'b011, 32'd0, 1'b1);
        txn("lw0", 0, 1'b0, 32'h0, 32'd0, 3'b010, 32'h01020304, 1'b0);
        chk("err.nowrite", wr_count, wr_base);

        // Back-to-back loads with valid held; requester 1 joins mid-stream.
        drive(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b010);
        #1;
        chk("b2b.ready0", {30'd0, bus.req_ready}, 32'd1);
        tick();
        chk("b2b.acc.re", {31'd0, bus.mem_read_enable}, 32'd1);
        chk("b2b.acc.valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("b2b.acc.ready", {30'd0, bus.req_ready}, 32'd0);
        tick();
        chk("b2b.rsp1.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("b2b.rsp1.rdata", bus.rsp_rdata, 32'hA5A5A5A5);
        chk("b2b.rsp1.ready", {30'd0, bus.req_ready}, 32'd1);
        tick();
        chk("b2b.acc2.valid", {30'd0, bus.rsp_valid}, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
        #1;
        chk("b2b.acc2.ready", {30'd0, bus.req_ready}, 32'd0);
        tick();
        chk("b2b.rsp2.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("b2b.rsp2.rdata", bus.rsp_rdata, 32'hA5A5A5A5);
        chk("b2b.rsp2.grant1", {30'd0, bus.req_ready}, 32'd2);
        tick();
        drive(1, 1'b0, 1'b0, 32'h10, 32'd0, 3'b010);
        chk("b2b.acc3.valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("b2b.acc3.addr", bus.mem_address, 32'h10);
        tick();
        chk("b2b.rsp3.valid", {30'd0, bus.rsp_valid}, 32'd2);
        chk("b2b.rsp3.rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("b2b.rsp3.ready", {30'd0, bus.req_ready}, 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'h30, 32'd0, 3'b010);
        chk("b2b.acc4.addr", bus.mem_address, 32'h30);
        tick();
        chk("b2b.rsp4.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("b2b.rsp4.rdata", bus.rsp_rdata, 32'hA5A5A5A5);
        tick();
        chk("b2b.idle", {30'd0, bus.rsp_valid}, 32'd0);

        // Reset during the ACCESS cycle of a store.
        wr_base = wr_count;
        drive(1, 1'b1, 1'b1, 32'h30, 32'h12345678, 3'b010);
        #1;
        chk("rstmid.ready", {30'd0, bus.req_ready}, 32'd2);
        tick();
        drive(1, 1'b0, 1'b1, 32'h30, 32'h12345678, 3'b010);
        chk("rstmid.we", {31'd0, bus.mem_write_enable}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.en_drop", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        chk("rstmid.valid", {30'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rstpost.valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rstpost.en", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        chk("rstpost.ready", {30'd0, bus.req_ready}, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
        #1;
        chk("rstpost.grant0", {30'd0, bus.req_ready}, 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'h30, 32'd0, 3'b010);
        chk("rstpost.acc.ready", {30'd0, bus.req_ready}, 32'd0);
        tick();
        chk("rstpost.rsp0.valid", {30'd0, bus.rsp_valid}, 32'd1);
        chk("rstpost.rsp0.rdata", bus.rsp_rdata, 32'hA5A5A5A5);
        chk("rstpost.grant1", {30'd0, bus.req_ready}, 32'd2);
        tick();
        drive(1, 1'b0, 1'b0, 32'h10, 32'd0, 3'b010);
        tick();
        chk("rstpost.rsp1.valid", {30'd0, bus.rsp_valid}, 32'd2);
        chk("rstpost.rsp1.rdata", bus.rsp_rdata, 32'hDEADBEEF);
        tick();
        chk("rstpost.idle", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rstpost.nowrite", wr_count, wr_base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
